// File: rtl/imem_boot_ctrl.sv
// Instruction memory front end: the CPU fetches combinationally while idle;
// a boot loader packs incoming bytes little-endian into words and writes them
// sequentially from word 0 while the CPU is stalled on NOPs.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | CPU owns the memory port, fetch is combinational
// S_LOAD  | collecting bytes of the current word (byte_ready high)
// S_WRITE | one-cycle write of the assembled word at the pointer
// S_DONE  | one-cycle boot_done pulse, then back to idle
module imem_boot_ctrl #(
   parameter int          ADDR_W   = 18,
   parameter int          LEN_W    = ADDR_W + 1,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              boot_start,
   input  logic [LEN_W-1:0]  boot_len,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              boot_busy,
   output logic              boot_done,
   input  logic [31:0]       cpu_PC,
   output logic [31:0]       cpu_inst,
   output logic              cpu_stall,
   output logic              cpu_misalign,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_we,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_ptr;
   logic [LEN_W-1:0]    r_len;
   logic [1:0]          r_bcnt;
   logic [23:0]         r_word;
   logic [31:0]         r_wdata;

   logic                w_start;
   logic                w_accept;
   logic                w_last;
   logic                w_unused_pc;

   // PC bits above the memory depth are deliberately dropped (address wraps)
   assign w_unused_pc = ^cpu_PC[31:ADDR_W+2];

   assign w_start  = boot_start && (boot_len != '0);
   assign w_accept = byte_valid && (r_state == S_LOAD);
   // Completion is decided against the latched length, not the pointer,
   // so a full-depth load finishes even though the pointer wraps to 0.
   assign w_last   = (LEN_W'(r_ptr) + LEN_W'(1)) == r_len;

   assign mem_wdata = r_wdata;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and output decode
   always_comb begin
      w_state_nxt  = r_state;
      byte_ready   = 1'b0;
      boot_busy    = 1'b1;
      boot_done    = 1'b0;
      mem_we       = 1'b0;
      cpu_stall    = 1'b1;
      cpu_inst     = NOP_INST;
      cpu_misalign = 1'b0;
      mem_addr     = r_ptr;
      case (r_state)
         S_IDLE: begin
            boot_busy = 1'b0;
            cpu_stall = 1'b0;
            mem_addr  = cpu_PC[ADDR_W+1:2];
            if (cpu_PC[1:0] == 2'b00) begin
               cpu_inst = mem_rdata;
            end else begin
               cpu_misalign = 1'b1;
            end
            if (w_start) begin
               w_state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            byte_ready = 1'b1;
            if (w_accept && (r_bcnt == 2'd3)) begin
               w_state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            mem_we      = 1'b1;
            w_state_nxt = w_last ? S_DONE : S_LOAD;
         end
         S_DONE: begin
            boot_done   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Boot datapath: length latch, byte packing, write pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= '0;
         r_len   <= '0;
         r_bcnt  <= 2'd0;
         r_word  <= 24'd0;
         r_wdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_len  <= boot_len;
                  r_ptr  <= '0;
                  r_bcnt <= 2'd0;
               end
            end
            S_LOAD: begin
               if (w_accept) begin
                  r_bcnt <= r_bcnt + 2'd1;
                  case (r_bcnt)
                     2'd0:    r_word[7:0]   <= byte_data;
                     2'd1:    r_word[15:8]  <= byte_data;
                     2'd2:    r_word[23:16] <= byte_data;
                     default: r_wdata       <= {byte_data, r_word};
                  endcase
               end
            end
            S_WRITE: begin
               r_ptr <= r_ptr + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

endmodule
